// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, writeback state encoding and decode helper.
package mips_pkg;

  localparam logic [5:0]  OP_RTYPE      = 6'h00;
  localparam logic [5:0]  FN_MFHI       = 6'h10;
  localparam logic [5:0]  FN_MFLO       = 6'h12;

  localparam logic [31:0] HALT_CODE_DEF = 32'd10;
  localparam logic [31:0] SHOW_CODE_DEF = 32'd34;

  localparam logic [4:0]  RA_REG        = 5'd31;
  localparam logic [31:0] LINK_OFFSET   = 32'd8;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } wb_state_e;

  // True for an R-type instruction carrying the given funct field.
  function automatic logic is_rtype_fn(input logic [31:0] ir, input logic [5:0] fn);
    return (ir[31:26] == OP_RTYPE) && (ir[5:0] == fn);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB pipeline register outputs plus the register-file write port.
interface wb_stage_if;

  logic [31:0] IR;
  logic [31:0] PC;
  logic [31:0] R1;
  logic [31:0] R2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  WbRegNum;
  logic        RegWrite;
  logic        LOWrite;
  logic        HIWrite;
  logic        JAL;
  logic        SYSCALL;

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  modport master (
    output IR, PC, R1, R2, RD1, RD2, WbRegNum,
    output RegWrite, LOWrite, HIWrite, JAL, SYSCALL,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  IR, PC, R1, R2, RD1, RD2, WbRegNum,
    input  RegWrite, LOWrite, HIWrite, JAL, SYSCALL,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/wb_syscall_fsm.sv
// SYSCALL halt/display controller with retired-instruction and RUN-cycle counters.
//   state | meaning
//   RUN   | pipeline advancing; instructions retire and counters run
//   HALT  | halt syscall seen; pipeline frozen until go
module wb_syscall_fsm
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
  parameter logic [31:0] SHOW_CODE = SHOW_CODE_DEF
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        go,
  input  logic        ir_valid,
  input  logic        syscall,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  output logic        retire,
  output logic        halted,
  output logic [31:0] disp,
  output logic        disp_stb,
  output logic [31:0] instr_cnt,
  output logic [31:0] cycle_cnt
);

  wb_state_e state;
  logic      running;

  assign running = (state == RUN);
  assign halted  = (state == HALT);
  assign retire  = ir_valid & running;

  // Counters are written every cycle so the next value always derives from the current one.
  always_ff @(posedge clk) begin
    if (CLR) begin
      state     <= RUN;
      disp      <= '0;
      disp_stb  <= 1'b0;
      instr_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      disp_stb  <= 1'b0;
      instr_cnt <= instr_cnt + {31'b0, retire};
      cycle_cnt <= cycle_cnt + {31'b0, running};
      case (state)
        RUN: begin
          if (retire && syscall) begin
            if (rd1 == HALT_CODE) begin
              state <= HALT;
            end else if (rd1 == SHOW_CODE) begin
              disp     <= rd2;
              disp_stb <= 1'b1;
            end
          end
        end
        HALT: begin
          if (go) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS writeback stage: register-file write mux, architectural LO/HI, and SYSCALL control.
module wb_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
  parameter logic [31:0] SHOW_CODE = SHOW_CODE_DEF
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic        go,
  wb_stage_if.slave   wb,
  output logic [31:0] LO,
  output logic [31:0] HI,
  output logic        halted,
  output logic [31:0] disp,
  output logic        disp_stb,
  output logic [31:0] instr_cnt,
  output logic [31:0] cycle_cnt
);

  logic        retire;
  logic        ir_valid;
  logic        is_mfhi;
  logic        is_mflo;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  assign ir_valid = (wb.IR != 32'd0);
  assign is_mfhi  = is_rtype_fn(wb.IR, FN_MFHI);
  assign is_mflo  = is_rtype_fn(wb.IR, FN_MFLO);

  always_comb begin
    wdata = wb.R1;
    if (wb.JAL) begin
      wdata = wb.PC + LINK_OFFSET;
    end else if (is_mfhi) begin
      wdata = HI;
    end else if (is_mflo) begin
      wdata = LO;
    end
  end

  assign waddr       = wb.JAL ? RA_REG : wb.WbRegNum;
  assign wb.rf_waddr = waddr;
  assign wb.rf_wdata = wdata;
  assign wb.rf_we    = wb.RegWrite & ~halted & ~CLR & (waddr != 5'd0);

  // mfhi/mflo see the registered value; MEM/WB never holds a writer and reader together.
  always_ff @(posedge clk) begin
    if (CLR) begin
      LO <= '0;
      HI <= '0;
    end else if (retire) begin
      if (wb.LOWrite) begin
        LO <= wb.R1;
      end
      if (wb.HIWrite) begin
        HI <= wb.R2;
      end
    end
  end

  wb_syscall_fsm #(
    .HALT_CODE (HALT_CODE),
    .SHOW_CODE (SHOW_CODE)
  ) u_fsm (
    .clk       (clk),
    .CLR       (CLR),
    .go        (go),
    .ir_valid  (ir_valid),
    .syscall   (wb.SYSCALL),
    .rd1       (wb.RD1),
    .rd2       (wb.RD2),
    .retire    (retire),
    .halted    (halted),
    .disp      (disp),
    .disp_stb  (disp_stb),
    .instr_cnt (instr_cnt),
    .cycle_cnt (cycle_cnt)
  );

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; counters tracked by a small cycle model.
module tb_wb_stage;

  localparam logic [31:0] ADD_IR  = 32'h01095020;
  localparam logic [31:0] MULT_IR = 32'h01090018;
  localparam logic [31:0] MFLO_IR = 32'h00004812;
  localparam logic [31:0] MFHI_IR = 32'h00004810;
  localparam logic [31:0] SYSC_IR = 32'h0000000C;
  localparam logic [31:0] JAL_IR  = 32'h0C100004;

  logic        clk;
  logic        CLR;
  logic        go;
  logic [31:0] LO, HI, disp, instr_cnt, cycle_cnt;
  logic        halted, disp_stb;

  int compared = 0;
  int mismatched = 0;

  logic        exp_halted = 1'b0;
  logic [31:0] exp_cycle  = 32'd0;
  logic [31:0] exp_instr  = 32'd0;

  wb_stage_if bus ();

  wb_stage #(
    .HALT_CODE (32'd10),
    .SHOW_CODE (32'd34)
  ) dut (
    .clk       (clk),
    .CLR       (CLR),
    .go        (go),
    .wb        (bus),
    .LO        (LO),
    .HI        (HI),
    .halted    (halted),
    .disp      (disp),
    .disp_stb  (disp_stb),
    .instr_cnt (instr_cnt),
    .cycle_cnt (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference for the counters and halt state, from bench-driven inputs only.
  always @(posedge clk) begin
    if (CLR) begin
      exp_halted = 1'b0;
      exp_cycle  = 32'd0;
      exp_instr  = 32'd0;
    end else if (!exp_halted) begin
      exp_cycle = exp_cycle + 32'd1;
      if (bus.IR != 32'd0) begin
        exp_instr = exp_instr + 32'd1;
        if (bus.SYSCALL && bus.RD1 == 32'd10) exp_halted = 1'b1;
      end
    end else if (go) begin
      exp_halted = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_idle();
    bus.IR = 32'd0; bus.PC = 32'd0; bus.R1 = 32'd0; bus.R2 = 32'd0;
    bus.RD1 = 32'd0; bus.RD2 = 32'd0; bus.WbRegNum = 5'd0;
    bus.RegWrite = 1'b0; bus.LOWrite = 1'b0; bus.HIWrite = 1'b0;
    bus.JAL = 1'b0; bus.SYSCALL = 1'b0;
  endtask

  task automatic test_reset();
    CLR = 1'b1; go = 1'b0;
    drive_idle();
    bus.IR = ADD_IR; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++; if (bus.rf_we !== 1'b0) begin mismatched++; $display("FAIL reset_rf_we: got %b want 0", bus.rf_we); end
    CLR = 1'b0;
    drive_idle();
    #1;
    compared++; if (LO !== 32'd0) begin mismatched++; $display("FAIL reset_lo: got %h want 0", LO); end
    compared++; if (HI !== 32'd0) begin mismatched++; $display("FAIL reset_hi: got %h want 0", HI); end
    compared++; if (disp !== 32'd0) begin mismatched++; $display("FAIL reset_disp: got %h want 0", disp); end
    compared++; if (disp_stb !== 1'b0) begin mismatched++; $display("FAIL reset_disp_stb: got %b want 0", disp_stb); end
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL reset_halted: got %b want 0", halted); end
    compared++; if (instr_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_instr_cnt: got %h want 0", instr_cnt); end
    compared++; if (cycle_cnt !== 32'd0) begin mismatched++; $display("FAIL reset_cycle_cnt: got %h want 0", cycle_cnt); end
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    drive_idle();
    bus.IR = ADD_IR; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd8; bus.R1 = 32'h1234;
    #1;
    compared++; if (bus.rf_we !== 1'b1) begin mismatched++; $display("FAIL alu_we: got %b want 1", bus.rf_we); end
    compared++; if (bus.rf_waddr !== 5'd8) begin mismatched++; $display("FAIL alu_addr: got %0d want 8", bus.rf_waddr); end
    compared++; if (bus.rf_wdata !== 32'h1234) begin mismatched++; $display("FAIL alu_data: got %h want 1234", bus.rf_wdata); end
    @(negedge clk);
    bus.WbRegNum = 5'd0;
    #1;
    compared++; if (bus.rf_we !== 1'b0) begin mismatched++; $display("FAIL zero_reg_we: got %b want 0", bus.rf_we); end
  endtask

  task automatic test_jal();
    @(negedge clk);
    drive_idle();
    bus.IR = JAL_IR; bus.JAL = 1'b1; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd5;
    bus.PC = 32'h00400010; bus.R1 = 32'h1111;
    #1;
    compared++; if (bus.rf_we !== 1'b1) begin mismatched++; $display("FAIL jal_we: got %b want 1", bus.rf_we); end
    compared++; if (bus.rf_waddr !== 5'd31) begin mismatched++; $display("FAIL jal_addr: got %0d want 31", bus.rf_waddr); end
    compared++; if (bus.rf_wdata !== 32'h00400018) begin mismatched++; $display("FAIL jal_data: got %h want 00400018", bus.rf_wdata); end
  endtask

  task automatic test_mult_lo_hi();
    @(negedge clk);
    drive_idle();
    bus.IR = MULT_IR; bus.LOWrite = 1'b1; bus.HIWrite = 1'b1;
    bus.R1 = 32'h0000AAAA; bus.R2 = 32'h00005555;
    @(posedge clk); #1;
    compared++; if (LO !== 32'h0000AAAA) begin mismatched++; $display("FAIL mult_lo: got %h want 0000aaaa", LO); end
    compared++; if (HI !== 32'h00005555) begin mismatched++; $display("FAIL mult_hi: got %h want 00005555", HI); end
    @(negedge clk);
    drive_idle();
    bus.IR = MFLO_IR; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd9; bus.R1 = 32'h0777;
    #1;
    compared++; if (bus.rf_wdata !== 32'h0000AAAA) begin mismatched++; $display("FAIL mflo_data: got %h want 0000aaaa", bus.rf_wdata); end
    compared++; if (bus.rf_waddr !== 5'd9) begin mismatched++; $display("FAIL mflo_addr: got %0d want 9", bus.rf_waddr); end
    @(negedge clk);
    bus.IR = MFHI_IR;
    #1;
    compared++; if (bus.rf_wdata !== 32'h00005555) begin mismatched++; $display("FAIL mfhi_data: got %h want 00005555", bus.rf_wdata); end
    compared++; if (instr_cnt !== exp_instr) begin mismatched++; $display("FAIL mult_instr_cnt: got %h want %h", instr_cnt, exp_instr); end
    compared++; if (cycle_cnt !== exp_cycle) begin mismatched++; $display("FAIL mult_cycle_cnt: got %h want %h", cycle_cnt, exp_cycle); end
  endtask

  task automatic test_show_halt();
    @(negedge clk);
    drive_idle();
    bus.IR = SYSC_IR; bus.SYSCALL = 1'b1; bus.RD1 = 32'd34; bus.RD2 = 32'hDEADBEEF;
    @(posedge clk); #1;
    compared++; if (disp !== 32'hDEADBEEF) begin mismatched++; $display("FAIL show_disp: got %h want deadbeef", disp); end
    compared++; if (disp_stb !== 1'b1) begin mismatched++; $display("FAIL show_stb_high: got %b want 1", disp_stb); end
    @(negedge clk);
    drive_idle();
    bus.IR = SYSC_IR; bus.SYSCALL = 1'b1; bus.RD1 = 32'd5; bus.RD2 = 32'h12345678;
    @(posedge clk); #1;
    compared++; if (disp_stb !== 1'b0) begin mismatched++; $display("FAIL show_stb_low: got %b want 0", disp_stb); end
    compared++; if (disp !== 32'hDEADBEEF) begin mismatched++; $display("FAIL noop_sys_disp: got %h want deadbeef", disp); end
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL noop_sys_halted: got %b want 0", halted); end
    // go arrives with the halt syscall: halt must still be taken
    @(negedge clk);
    drive_idle();
    bus.IR = SYSC_IR; bus.SYSCALL = 1'b1; bus.RD1 = 32'd10; go = 1'b1;
    @(posedge clk); #1;
    compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_enter: got %b want 1", halted); end
    @(negedge clk);
    go = 1'b0;
    drive_idle();
    bus.IR = ADD_IR; bus.RegWrite = 1'b1; bus.WbRegNum = 5'd8; bus.LOWrite = 1'b1; bus.R1 = 32'h9999;
    #1;
    compared++; if (bus.rf_we !== 1'b0) begin mismatched++; $display("FAIL halt_rf_we: got %b want 0", bus.rf_we); end
    repeat (3) @(posedge clk);
    #1;
    compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL halt_hold: got %b want 1", halted); end
    compared++; if (LO !== 32'h0000AAAA) begin mismatched++; $display("FAIL halt_lo: got %h want 0000aaaa", LO); end
    compared++; if (instr_cnt !== exp_instr) begin mismatched++; $display("FAIL halt_instr_cnt: got %h want %h", instr_cnt, exp_instr); end
    compared++; if (cycle_cnt !== exp_cycle) begin mismatched++; $display("FAIL halt_cycle_cnt: got %h want %h", cycle_cnt, exp_cycle); end
    @(negedge clk);
    drive_idle();
    go = 1'b1;
    @(posedge clk); #1;
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL go_resume: got %b want 0", halted); end
    @(negedge clk);
    go = 1'b0;
    bus.IR = ADD_IR;
    @(posedge clk); #1;
    compared++; if (instr_cnt !== exp_instr) begin mismatched++; $display("FAIL resume_instr_cnt: got %h want %h", instr_cnt, exp_instr); end
    compared++; if (cycle_cnt !== exp_cycle) begin mismatched++; $display("FAIL resume_cycle_cnt: got %h want %h", cycle_cnt, exp_cycle); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    drive_idle();
    force dut.u_fsm.instr_cnt = 32'hFFFFFFFF;
    exp_instr = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.u_fsm.instr_cnt;
    #1;
    compared++; if (instr_cnt !== 32'hFFFFFFFF) begin mismatched++; $display("FAIL wrap_preload: got %h want ffffffff", instr_cnt); end
    bus.IR = ADD_IR;
    @(posedge clk); #1;
    compared++; if (instr_cnt !== 32'd0) begin mismatched++; $display("FAIL wrap_instr_cnt: got %h want 0", instr_cnt); end
  endtask

  task automatic test_go_with_clr();
    @(negedge clk);
    drive_idle();
    bus.IR = SYSC_IR; bus.SYSCALL = 1'b1; bus.RD1 = 32'd10;
    @(posedge clk); #1;
    compared++; if (halted !== 1'b1) begin mismatched++; $display("FAIL clr_pre_halt: got %b want 1", halted); end
    @(negedge clk);
    drive_idle();
    go = 1'b1; CLR = 1'b1;
    bus.RegWrite = 1'b1; bus.WbRegNum = 5'd3;
    #1;
    compared++; if (bus.rf_we !== 1'b0) begin mismatched++; $display("FAIL clr_rf_we: got %b want 0", bus.rf_we); end
    @(posedge clk); #1;
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL clr_halted: got %b want 0", halted); end
    compared++; if (LO !== 32'd0 || HI !== 32'd0) begin mismatched++; $display("FAIL clr_lo_hi: got %h/%h want 0/0", LO, HI); end
    compared++; if (disp !== 32'd0) begin mismatched++; $display("FAIL clr_disp: got %h want 0", disp); end
    compared++; if (instr_cnt !== 32'd0 || cycle_cnt !== 32'd0) begin mismatched++; $display("FAIL clr_counters: got %h/%h want 0/0", instr_cnt, cycle_cnt); end
    @(negedge clk);
    go = 1'b0; CLR = 1'b0;
    drive_idle();
    bus.IR = ADD_IR;
    @(posedge clk); #1;
    compared++; if (instr_cnt !== 32'd1 || cycle_cnt !== 32'd1) begin mismatched++; $display("FAIL clr_run_counts: got %h/%h want 1/1", instr_cnt, cycle_cnt); end
    compared++; if (halted !== 1'b0) begin mismatched++; $display("FAIL clr_run_state: got %b want 0", halted); end
  endtask

  initial begin
    CLR = 1'b1;
    go  = 1'b0;
    drive_idle();
    test_reset();
    test_alu_write();
    test_jal();
    test_mult_lo_hi();
    test_show_halt();
    test_wrap();
    test_go_with_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
